// File: rtl/stage_mux_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_mux_seq: CH:1 registered selector over FFT stage outputs, stepped  |
// | by an AUTO sequencer or driven by an external MANUAL select. Rev 1.0     |
// +--------------------------------------------------------------------------+
module stage_mux_seq #(
  parameter int N     = 16,
  parameter int CH    = 6,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH*N-1:0]   din,
  input  logic              in_valid,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_manual,
  input  logic              start,
  input  logic              adv,
  output logic [N-1:0]      dout,
  output logic              dout_valid,
  output logic [SEL_W-1:0]  cur_sel,
  output logic              busy,
  output logic              done,
  output logic              sel_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CH - 1);
  // One bit wider so CH itself is representable when 2^SEL_W == CH.
  localparam logic [SEL_W:0]   CH_EXT  = (SEL_W + 1)'(CH);

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic [N-1:0]     chan [CH];
  logic [N-1:0]     sel_word;
  logic             sel_ok;

  for (genvar k = 0; k < CH; k++) begin : g_chan
    assign chan[k] = din[k*N +: N];
  end

  // Out-of-range selects fall through every compare and leave sel_word at zero.
  always_comb begin
    cur_sel  = mode ? sel_manual : cnt;
    sel_ok   = {1'b0, cur_sel} < CH_EXT;
    sel_word = '0;
    for (int k = 0; k < CH; k++) begin
      if (cur_sel == SEL_W'(k)) sel_word = chan[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !mode) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (mode) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (adv) begin
            if (cnt == LAST_CH) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // MANUAL takes precedence whenever mode is high, including during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sel_err    <= 1'b0;
    end else if (in_valid && mode) begin
      dout       <= sel_word;
      dout_valid <= 1'b1;
      sel_err    <= !sel_ok;
    end else if (in_valid && state == RUN) begin
      dout       <= sel_word;
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
